// File: rtl/hamm_route_scheduler.sv
// Four requesters share one Hamming(7,4) encode / fault-inject / correct path.
// Round-robin grant, two register stages, per-destination corrected-error counters.
module hamm_route_scheduler #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req_valid,
  input  logic [15:0]        req_data,
  input  logic [7:0]         req_dest,
  output logic [3:0]         req_ready,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_dest,
  input  logic [2:0]         cfg_pos,
  input  logic               clr_cnt,
  output logic [3:0]         out_valid,
  output logic [3:0]         out_data,
  output logic               out_corr,
  output logic [4*CNT_W-1:0] err_cnt,
  output logic               busy
);

  logic [1:0]       ptr_reg;
  logic [3:0]       grant;
  logic [1:0]       grant_idx;
  logic             grant_any;
  logic [1:0]       arb_idx;

  logic [7:1]       enc_code [4];
  logic [2:0]       fault_pos_reg [4];
  logic [1:0]       sel_dest;
  logic [7:1]       sel_code;
  logic [2:0]       sel_pos;
  logic [7:1]       sel_mask;

  logic             s1_valid_reg;
  logic [1:0]       s1_dest_reg;
  logic [7:1]       s1_code_reg;
  logic [2:0]       syn;
  logic [3:0]       corr_data;

  logic [CNT_W-1:0] cnt_reg [4];

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant     = 4'b0000;
    grant_idx = ptr_reg;
    grant_any = 1'b0;
    arb_idx   = ptr_reg;
    for (int k = 1; k <= 4; k++) begin
      arb_idx = ptr_reg + 2'(k);
      if (!grant_any && req_valid[arb_idx]) begin
        grant_any       = 1'b1;
        grant_idx       = arb_idx;
        grant[arb_idx]  = 1'b1;
      end
    end
  end

  assign req_ready = grant;

  // Codeword vector index equals Hamming position: [7:1] = d4 d3 d2 p4 d1 p2 p1.
  for (genvar gi = 0; gi < 4; gi++) begin : g_enc
    logic d1, d2, d3, d4;
    assign d1 = req_data[4*gi+3];
    assign d2 = req_data[4*gi+2];
    assign d3 = req_data[4*gi+1];
    assign d4 = req_data[4*gi];
    assign enc_code[gi] = {d4, d3, d2, d2 ^ d3 ^ d4, d1, d1 ^ d3 ^ d4, d1 ^ d2 ^ d4};
  end

  assign sel_dest = req_dest[2*grant_idx +: 2];
  assign sel_code = enc_code[grant_idx];
  assign sel_pos  = fault_pos_reg[sel_dest];
  assign sel_mask = (sel_pos == 3'd0) ? 7'b0 : 7'(7'b1 << (sel_pos - 3'd1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg      <= 2'd3;
      s1_valid_reg <= 1'b0;
      s1_dest_reg  <= 2'd0;
      s1_code_reg  <= 7'd0;
      for (int k = 0; k < 4; k++) fault_pos_reg[k] <= 3'd0;
    end else begin
      if (grant_any) ptr_reg <= grant_idx;
      s1_valid_reg <= grant_any;
      if (grant_any) begin
        s1_dest_reg <= sel_dest;
        s1_code_reg <= sel_code ^ sel_mask;
      end
      if (cfg_we) fault_pos_reg[cfg_dest] <= cfg_pos;
    end
  end

  assign syn[0] = s1_code_reg[1] ^ s1_code_reg[3] ^ s1_code_reg[5] ^ s1_code_reg[7];
  assign syn[1] = s1_code_reg[2] ^ s1_code_reg[3] ^ s1_code_reg[6] ^ s1_code_reg[7];
  assign syn[2] = s1_code_reg[4] ^ s1_code_reg[5] ^ s1_code_reg[6] ^ s1_code_reg[7];

  // Only data positions matter for the delivered payload; parity flips are discarded.
  assign corr_data = {s1_code_reg[3] ^ (syn == 3'd3),
                      s1_code_reg[5] ^ (syn == 3'd5),
                      s1_code_reg[6] ^ (syn == 3'd6),
                      s1_code_reg[7] ^ (syn == 3'd7)};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 4'b0000;
      out_data  <= 4'b0000;
      out_corr  <= 1'b0;
    end else begin
      out_valid <= s1_valid_reg ? (4'b0001 << s1_dest_reg) : 4'b0000;
      if (s1_valid_reg) begin
        out_data <= corr_data;
        out_corr <= (syn != 3'd0);
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (!rst_n || clr_cnt) begin
        cnt_reg[gi] <= '0;
      end else if (s1_valid_reg && (s1_dest_reg == 2'(gi)) && (syn != 3'd0)
                   && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
        cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
      end
    end
    assign err_cnt[gi*CNT_W +: CNT_W] = cnt_reg[gi];
  end

  assign busy = s1_valid_reg | (|out_valid);

endmodule

// File: tb/tb_hamm_route_scheduler.sv
// Directed bench for hamm_route_scheduler: arbitration order, latency, fault
// correction, counter saturation/clear, config timing and mid-flight reset.
module tb_hamm_route_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [7:0]  req_dest;
  logic [3:0]  req_ready;
  logic        cfg_we;
  logic [1:0]  cfg_dest;
  logic [2:0]  cfg_pos;
  logic        clr_cnt;
  logic [3:0]  out_valid;
  logic [3:0]  out_data;
  logic        out_corr;
  logic [31:0] err_cnt;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  hamm_route_scheduler #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_dest(req_dest), .req_ready(req_ready),
    .cfg_we(cfg_we), .cfg_dest(cfg_dest), .cfg_pos(cfg_pos), .clr_cnt(clr_cnt),
    .out_valid(out_valid), .out_data(out_data), .out_corr(out_corr),
    .err_cnt(err_cnt), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One line per delivered transaction.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid != 4'b0000)
      $display("[TB] t=%0t deliver valid=%b data=%b corr=%b", $time, out_valid, out_data, out_corr);
  end

  task automatic step();
    @(negedge clk);
  endtask

  logic [3:0] pay [4];

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_dest = '0;
    cfg_we = 1'b0; cfg_dest = '0; cfg_pos = '0; clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    step();
    rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_corr", 32'(out_corr), 32'h0);
    check("rst_err_cnt", err_cnt, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // Clean send of 1011 to dest 2 from requester 0.
    step();
    req_valid = 4'b0001; req_data = 16'h000B; req_dest = 8'h02;
    #1 check("t1_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0000;
    check("t1_codeword", 32'(dut.s1_code_reg), 32'b1100110);
    check("t1_busy", 32'(busy), 32'h1);
    step();
    check("t1_out_valid", 32'(out_valid), 32'h4);
    check("t1_out_data", 32'(out_data), 32'hB);
    check("t1_out_corr", 32'(out_corr), 32'h0);
    check("t1_err_cnt", err_cnt, 32'h0);

    // Fault at position 3 (d1) for dest 1.
    cfg_we = 1'b1; cfg_dest = 2'd1; cfg_pos = 3'd3;
    step();
    cfg_we = 1'b0;
    req_valid = 4'b0001; req_data = 16'h000B; req_dest = 8'h01;
    step();
    req_valid = 4'b0000;
    step();
    check("t2_out_valid", 32'(out_valid), 32'h2);
    check("t2_out_data", 32'(out_data), 32'hB);
    check("t2_out_corr", 32'(out_corr), 32'h1);
    check("t2_err_cnt", err_cnt, 32'h0000_0100);
    clr_cnt = 1'b1; cfg_we = 1'b1; cfg_dest = 2'd1; cfg_pos = 3'd0;
    step();
    clr_cnt = 1'b0; cfg_we = 1'b0;
    #1 check("t2_cleared", err_cnt, 32'h0);

    // Round-robin order after reset with all requesters active.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    pay[0] = 4'h3; pay[1] = 4'hA; pay[2] = 4'h6; pay[3] = 4'hC;
    req_data = 16'hC6A3; req_dest = 8'b11_10_01_00;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      req_valid = (i < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (i < 8) check($sformatf("rr_ready%0d", i), 32'(req_ready), 32'(4'b0001 << (i % 4)));
      if (i >= 1) check($sformatf("rr_busy%0d", i), 32'(busy), 32'h1);
      if (i >= 2) begin
        check($sformatf("rr_valid%0d", i), 32'(out_valid), 32'(4'b0001 << ((i - 2) % 4)));
        check($sformatf("rr_data%0d", i), 32'(out_data), 32'(pay[(i - 2) % 4]));
        check($sformatf("rr_corr%0d", i), 32'(out_corr), 32'h0);
      end
    end

    // Saturation: 260 corrected deliveries to dest 3.
    step();
    req_valid = 4'b0000;
    cfg_we = 1'b1; cfg_dest = 2'd3; cfg_pos = 3'd7;
    step();
    cfg_we = 1'b0;
    req_valid = 4'b0001; req_data = 16'h0009; req_dest = 8'h03;
    for (int i = 0; i < 260; i++) step();
    req_valid = 4'b0000;
    check("sat_corr", 32'(out_corr), 32'h1);
    check("sat_data", 32'(out_data), 32'h9);
    repeat (3) step();
    check("sat_err_cnt", err_cnt, 32'hFF00_0000);

    // Clear coinciding with a correcting delivery.
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000; clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("clr_out_valid", 32'(out_valid), 32'h8);
    check("clr_out_corr", 32'(out_corr), 32'h1);
    check("clr_err_cnt", err_cnt, 32'h0);
    cfg_we = 1'b1; cfg_dest = 2'd3; cfg_pos = 3'd0;
    step();
    cfg_we = 1'b0;

    // Config write on the same edge as an encode uses the old fault setting.
    cfg_we = 1'b1; cfg_dest = 2'd0; cfg_pos = 3'd5;
    req_valid = 4'b0001; req_data = 16'h0005; req_dest = 8'h00;
    step();
    cfg_we = 1'b0;
    step();
    req_valid = 4'b0000;
    check("cfg_old_valid", 32'(out_valid), 32'h1);
    check("cfg_old_corr", 32'(out_corr), 32'h0);
    check("cfg_old_data", 32'(out_data), 32'h5);
    step();
    check("cfg_new_valid", 32'(out_valid), 32'h1);
    check("cfg_new_corr", 32'(out_corr), 32'h1);
    check("cfg_new_data", 32'(out_data), 32'h5);
    check("cfg_err_cnt", err_cnt, 32'h1);

    // Reset with one transaction in stage 1 and another being granted.
    req_valid = 4'b0001; req_data = 16'h000E; req_dest = 8'h02;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; req_valid = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_drop_valid%0d", i), 32'(out_valid), 32'h0);
      check($sformatf("rst_drop_busy%0d", i), 32'(busy), 32'h0);
      step();
    end
    check("rst_drop_data", 32'(out_data), 32'h0);
    req_valid = 4'b1111;
    #1 check("rst_ptr_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
